// File: rtl/direction_input_ctrl.sv
// Debounced four-way direction input with a one-move-per-press handshake toward the game core.
// Optional auto-repeat while the last direction stays held: define DIR_REPEAT_EN.
module direction_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [1:0] game_state,
    input  logic       move_ack,
    output logic [3:0] direction,
    output logic       dir_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("direction_input_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RELEASE} state_t;

    logic [3:0]            raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [3:0]            dir_q, dir_d;
    logic                  one_hot, multi, playing;

    // Bit order matches the direction encoding: {right, left, bottom, top}.
    assign raw = {btn_right, btn_left, btn_down, btn_up};

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign one_hot = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);
    assign multi   = (deb_q != 4'd0) && !one_hot;
    assign playing = (game_state == 2'b01);

`ifdef DIR_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [3:0]       last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q  <= '0;
            last_q <= '0;
        end else begin
            rpt_q  <= rpt_d;
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
`ifdef DIR_REPEAT_EN
        rpt_d   = '0;
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (multi) begin
                    state_d = WAIT_RELEASE;
                end else if (one_hot && playing) begin
                    state_d = ISSUE;
                    dir_d   = deb_q;
`ifdef DIR_REPEAT_EN
                    last_d  = deb_q;
`endif
                end
            end
            ISSUE: begin
                // An ack and a leave-playing event have the same effect, so one branch covers both.
                if (move_ack || !playing) begin
                    state_d = WAIT_RELEASE;
                    dir_d   = 4'd0;
                end
            end
            WAIT_RELEASE: begin
                if (deb_q == 4'd0) begin
                    state_d = IDLE;
                end
`ifdef DIR_REPEAT_EN
                else if (one_hot && deb_q == last_q) begin
                    if (rpt_q == RPT_LAST) begin
                        state_d = ISSUE;
                        dir_d   = deb_q;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                dir_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    assign direction = dir_q;
    assign dir_valid = (state_q == ISSUE);

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Bench for direction_input_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_direction_input_ctrl;

    localparam int DEB = 4;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0] game_state = 2'b01;
    logic       move_ack = 1'b0;
    logic [3:0] direction;
    logic       dir_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    direction_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .game_state(game_state),
        .move_ack  (move_ack),
        .direction (direction),
        .dir_valid (dir_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw->two-stage delay, run-length debounce, and a pending-move /
    // blocked-until-release description of the handshake.
    logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
    int         m_run[4];
    logic [3:0] m_pend = '0, m_last = '0;
    bit         m_blk = 1'b0;
    int         m_rc = 0;

    always @(posedge clk) begin
        logic [3:0] dv;
        int ones;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_last = '0;
            m_blk = 1'b0; m_rc = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            dv = m_deb;
            ones = $countones(dv);
            if (m_pend != 4'd0) begin
                if (move_ack || game_state != 2'b01) begin
                    m_pend = '0;
                    m_blk = 1'b1;
                end
            end else if (m_blk) begin
                if (dv == 4'd0) begin
                    m_blk = 1'b0;
                    m_rc = 0;
                end
`ifdef DIR_REPEAT_EN
                else if (ones == 1 && dv == m_last) begin
                    m_rc++;
                    if (m_rc == REP) begin
                        m_pend = dv;
                        m_blk = 1'b0;
                        m_rc = 0;
                    end
                end else begin
                    m_rc = 0;
                end
`endif
            end else begin
                if (ones >= 2) m_blk = 1'b1;
                else if (ones == 1 && game_state == 2'b01) begin
                    m_pend = dv;
                    m_last = dv;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_right, btn_left, btn_down, btn_up};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_direction", direction, m_pend);
            check("model_dir_valid", {3'b0, dir_valid}, {3'b0, m_pend != 4'd0});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic settle();
        move_ack = 1'b1; set_btn(4'd0); game_state = 2'b01;
        tick(1);
        move_ack = 1'b0;
        tick(12);
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        tick(2);
    endtask

    initial begin
        int issues, cyc, ack_cyc, hold;
        bit seen;
        logic [3:0] b;

        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_direction", direction, 4'b0000);
        check("reset_valid", {3'b0, dir_valid}, 4'd0);

        // Left held while playing: valid after exactly 7 edges, held until ack.
        set_btn(4'b0100);
        tick(6);
        check("left_before_latency", {3'b0, dir_valid}, 4'd0);
        tick(1);
        check("left_direction", direction, 4'b0100);
        check("left_valid", {3'b0, dir_valid}, 4'd1);
        tick(3);
        check("left_held", direction, 4'b0100);
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        check("left_ack_dir", direction, 4'b0000);
        check("left_ack_valid", {3'b0, dir_valid}, 4'd0);
        settle();

        // Short press is filtered.
        set_btn(4'b0001);
        tick(3);
        set_btn(4'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (dir_valid) seen = 1'b1;
        end
        check("short_press_none", {3'b0, seen}, 4'd0);
        settle();

        // Two buttons together: no move; then a single down press issues.
        set_btn(4'b1001);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (dir_valid) seen = 1'b1;
        end
        check("chord_none", {3'b0, seen}, 4'd0);
        set_btn(4'd0);
        tick(10);
        set_btn(4'b0010);
        tick(7);
        check("down_after_chord", direction, 4'b0010);
        settle();

        // Not playing blocks the move; entering play issues it; losing cancels it.
        game_state = 2'b00;
        set_btn(4'b1000);
        tick(10);
        check("not_playing_none", {3'b0, dir_valid}, 4'd0);
        game_state = 2'b01;
        tick(1);
        check("play_start_right", direction, 4'b1000);
        game_state = 2'b11;
        tick(1);
        check("lose_cancel", {3'b0, dir_valid}, 4'd0);
        settle();

        // Reset while issuing drops the request; held button is re-debounced.
        set_btn(4'b0001);
        tick(7);
        check("up_issue", direction, 4'b0001);
        rst = 1'b1;
        tick(1);
        check("rst_clears_dir", direction, 4'b0000);
        check("rst_clears_valid", {3'b0, dir_valid}, 4'd0);
        rst = 1'b0;
        tick(6);
        check("reissue_not_early", {3'b0, dir_valid}, 4'd0);
        tick(1);
        check("reissue_up", direction, 4'b0001);
        settle();

        // Held down with an ack at every issue.
        set_btn(4'b0010);
        issues = 0; cyc = 0; ack_cyc = 0;
        for (int i = 0; i < 45; i++) begin
            tick(1);
            cyc++;
            if (dir_valid && !move_ack) begin
                issues++;
`ifdef DIR_REPEAT_EN
                if (ack_cyc > 0) check("repeat_gap", 4'(cyc - ack_cyc), 4'd8);
`endif
                move_ack = 1'b1;
                ack_cyc = cyc + 1;
            end else begin
                move_ack = 1'b0;
            end
        end
        move_ack = 1'b0;
`ifdef DIR_REPEAT_EN
        check("repeat_issue_count_ge3", {3'b0, issues >= 3}, 4'd1);
`else
        check("single_issue_no_repeat", 4'(issues), 4'd1);
`endif
        settle();

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: b = 4'b0001 << $urandom_range(0, 3);
                3:       b = 4'd0;
                default: b = 4'($urandom_range(0, 15));
            endcase
            set_btn(b);
            hold = $urandom_range(1, 14);
            for (int k = 0; k < hold; k++) begin
                game_state = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
                move_ack = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        rst = 1'b0; move_ack = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
